// File: rtl/l1ca_siggen_if.sv
// l1ca_siggen_if: PRN type and the burst request / sample stream bundle
package l1ca_pkg;
  typedef logic [5:0] sv_t;
endpackage

interface l1ca_siggen_if;
  import l1ca_pkg::*;
  logic        start;
  sv_t         sv;
  logic [10:0] code_phase_half;
  logic [4:0]  dop_index;
  logic        nav_bit;
  logic        out_ready;
  logic        sample_out;
  logic        out_valid;
  logic        busy;
  logic        done;
  modport master (
    output start, sv, code_phase_half, dop_index, nav_bit, out_ready,
    input  sample_out, out_valid, busy, done
  );
  modport slave (
    input  start, sv, code_phase_half, dop_index, nav_bit, out_ready,
    output sample_out, out_valid, busy, done
  );
endinterface

// File: rtl/l1ca_siggen.sv
// l1ca_siggen: GPS L1 C/A 1-bit IF burst generator; L1CA_SIGGEN_NOISE_EN adds LFSR sample flips
module l1ca_code
  import l1ca_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic       i_clr,
  input  logic       i_stb,
  input  sv_t        i_sv,
  output logic       o_code,
  output logic [9:0] o_chip
);
  localparam logic [7:0] TAPS [32] = '{
    8'h26, 8'h37, 8'h48, 8'h59, 8'h19, 8'h2a, 8'h18, 8'h29,
    8'h3a, 8'h23, 8'h34, 8'h56, 8'h67, 8'h78, 8'h89, 8'h9a,
    8'h14, 8'h25, 8'h36, 8'h47, 8'h58, 8'h69, 8'h13, 8'h46,
    8'h57, 8'h68, 8'h79, 8'h8a, 8'h16, 8'h27, 8'h38, 8'h49
  };
  logic [9:0] r_g1, r_g2, r_chip;
  logic [7:0] w_tap;
  assign w_tap  = TAPS[5'(i_sv - 6'd1)];
  assign o_code = r_g1[9] ^ r_g2[4'(w_tap[7:4] - 4'd1)] ^ r_g2[4'(w_tap[3:0] - 4'd1)];
  assign o_chip = r_chip;
  // G1/G2 shift once per strobe; chip index wraps with the 1023-chip period
  always_ff @(posedge clk)
    if (!nrst || i_clr) begin
      r_g1   <= '1;
      r_g2   <= '1;
      r_chip <= '0;
    end else if (i_stb) begin
      r_g1   <= {r_g1[8:0], r_g1[2] ^ r_g1[9]};
      r_g2   <= {r_g2[8:0], ^(r_g2 & 10'h3a6)};
      r_chip <= r_chip == 10'd1022 ? '0 : r_chip + 10'd1;
    end
endmodule

module l1ca_siggen
  import l1ca_pkg::*;
#(
  parameter int N_SAMPLES = 19200
) (
  input logic clk,
  input logic rst,
  l1ca_siggen_if.slave bus
);
  localparam logic [31:0] CODE_RATE = 32'd228841226;
  localparam logic [3:0]  LO_SIN    = 4'b0011;
  typedef enum logic [1:0] {IDLE, WIND, RUN} state_t;
  state_t      r_state, w_next;
  sv_t         r_sv;
  logic [10:0] r_cp;
  logic [4:0]  r_dop;
  logic        r_nav, r_done;
  logic [31:0] r_cnco, r_lnco, w_cnco_nx;
  logic [14:0] r_cnt;
  logic        w_run, w_hs, w_last, w_match, w_carry, w_stb, w_code, w_noise;
  logic [9:0]  w_chip;
  logic [31:0] w_tab [21];
  function automatic logic [31:0] lo_rate(input int n);
    return 32'((64'(8030 + n) * 64'd8388608) / 64'd75);
  endfunction
  for (genvar i = 0; i < 21; i++) begin : g_tab
    assign w_tab[i] = lo_rate(i);
  end
  assign w_run   = r_state == RUN;
  assign w_hs    = w_run && bus.out_ready;
  assign w_match = w_chip == r_cp[10:1];
  assign w_last  = r_cnt == 15'(N_SAMPLES - 1);
  assign w_stb   = r_state == WIND ? !w_match : w_hs && w_carry;
  assign {w_carry, w_cnco_nx} = {1'b0, r_cnco} + {1'b0, CODE_RATE};
  l1ca_code u_code (
    .clk(clk), .nrst(~rst), .i_clr(r_state == IDLE), .i_stb(w_stb),
    .i_sv(r_sv), .o_code(w_code), .o_chip(w_chip)
  );
`ifdef L1CA_SIGGEN_NOISE_EN
  logic [15:0] r_lfsr;
  // noise LFSR: reseeded per burst, one Galois step per accepted sample
  always_ff @(posedge clk)
    if (rst || (r_state == IDLE && bus.start)) r_lfsr <= 16'hACE1;
    else if (w_hs) r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0);
  assign w_noise = r_lfsr[2:0] == 3'b000;
`else
  assign w_noise = 1'b0;
`endif
  // state register
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  // next state and stream outputs
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && bus.start) w_next = WIND;
    if (r_state == WIND && w_match) w_next = RUN;
    if (w_hs && w_last) w_next = IDLE;
    bus.busy       = r_state != IDLE;
    bus.out_valid  = w_run;
    bus.done       = r_done;
    bus.sample_out = w_run && (w_code ^ r_nav ^ LO_SIN[r_lnco[31:30]] ^ w_noise);
  end
  // request latch with clamping, NCOs, sample counter and done pulse
  always_ff @(posedge clk)
    if (rst) begin
      r_sv   <= '0;
      r_cp   <= '0;
      r_dop  <= '0;
      r_nav  <= 1'b0;
      r_cnco <= '0;
      r_lnco <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_hs && w_last;
      if (r_state == IDLE && bus.start) begin
        r_sv  <= bus.sv;
        r_cp  <= bus.code_phase_half > 11'd2045 ? 11'd2045 : bus.code_phase_half;
        r_dop <= bus.dop_index > 5'd20 ? 5'd20 : bus.dop_index;
        r_nav <= bus.nav_bit;
      end
      if (r_state == WIND && w_match) begin
        r_cnco <= {r_cp[0], 31'b0};
        r_lnco <= '0;
        r_cnt  <= '0;
      end
      if (w_hs) begin
        r_cnco <= w_cnco_nx;
        r_lnco <= r_lnco + w_tab[r_dop];
        r_cnt  <= r_cnt + 15'd1;
      end
    end
endmodule

// File: tb/tb_l1ca_siggen.sv
// tb_l1ca_siggen: randomized bursts checked against a chip-count / phase-arithmetic model
module tb_l1ca_siggen;
  import l1ca_pkg::*;
  localparam int N = 19200;
  localparam longint CODE_RATE = 228841226;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int nd;
  bit g1s [1023];
  bit g2s [1023];
  int delay [32] = '{5, 6, 7, 8, 17, 18, 139, 140, 141, 251, 252, 254, 255, 256, 257, 258,
                     469, 470, 471, 472, 473, 474, 509, 512, 513, 514, 515, 516, 859, 860, 861, 862};
  l1ca_siggen_if bus();
  l1ca_siggen #(.N_SAMPLES(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit model(input int prn, input int cp, input int dop, input bit nav, input int s);
    longint unsigned lo, ph;
    int chip;
    lo   = (64'(8030 + dop) * 64'd8388608) / 64'd75;
    chip = int'(((64'(cp % 2) << 31) + 64'(s) * CODE_RATE) >> 32);
    chip = (chip + cp / 2) % 1023;
    ph   = (64'(s) * lo) % (64'd1 << 32);
    return g1s[chip] ^ g2s[(chip + 1023 - delay[prn - 1]) % 1023] ^ nav ^ (ph[31:30] < 2);
  endfunction

  task automatic burst(input int prn, input int cp, input int dop, input bit nav,
                       input int stall_at, input int abort_at, input int mid_at, input int pct,
                       output int ndiff);
    int ccp, cdp, cyc, s, stall, guard;
    bit e, stalled, held, prev;
    logic [15:0] lf;
    ccp = cp > 2045 ? 2045 : cp;
    cdp = dop > 20 ? 20 : dop;
    ndiff = 0;
    bus.sv = sv_t'(prn);
    bus.code_phase_half = 11'(cp);
    bus.dop_index = 5'(dop);
    bus.nav_bit = nav;
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.sv = sv_t'($urandom_range(1, 32));
    bus.code_phase_half = 11'($urandom);
    bus.dop_index = 5'($urandom);
    bus.nav_bit = 1'($urandom);
    cyc = 1;
    while (!bus.out_valid && cyc < 1100) begin
      check("wind_busy", bus.busy, 1);
      @(negedge clk);
      cyc++;
    end
    check("valid_latency", cyc, ccp / 2 + 2);
    s = 0; stall = 0; guard = 0; stalled = 0; held = 0; prev = 0;
    lf = 16'hACE1;
    while (s < N && guard < 25000) begin
      guard++;
      e = model(prn, ccp, cdp, nav, s);
`ifdef L1CA_SIGGEN_NOISE_EN
      e ^= (lf[2:0] == 3'b000);
`endif
      check("sample", bus.sample_out, e);
      check("run_flags", {bus.busy, bus.out_valid, bus.done}, 3'b110);
      if (held) check("stall_hold", bus.sample_out, prev);
      if (s == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check("abort_idle", {bus.busy, bus.out_valid, bus.done, bus.sample_out}, 4'b0000);
        rst = 1'b0;
        bus.start = 1'b0;
        return;
      end
      if (s == stall_at && !stalled) begin
        stall = 5;
        stalled = 1;
      end
      bus.out_ready = stall > 0 ? 1'b0 : ($urandom_range(1, 100) <= pct);
      if (stall > 0) stall--;
      bus.start = s == mid_at;
      held = !bus.out_ready;
      prev = bus.sample_out;
      @(negedge clk);
      if (bus.out_ready) begin
        s++;
        ndiff += int'(lf[2:0] == 3'b000);
        lf = {1'b0, lf[15:1]} ^ (lf[0] ? 16'hB400 : 16'h0);
      end
    end
    bus.start = 1'b0;
    check("handshakes", s, N);
    check("end_flags", {bus.busy, bus.out_valid, bus.done, bus.sample_out}, 4'b0010);
    @(negedge clk);
    check("done_once", {bus.busy, bus.done}, 2'b00);
  endtask

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [9:0] a, b;
    a = '1;
    b = '1;
    for (int n = 0; n < 1023; n++) begin
      g1s[n] = a[9];
      g2s[n] = b[9];
      a = {a[8:0], a[2] ^ a[9]};
      b = {b[8:0], ^(b & 10'h3a6)};
    end
    bus.start = 1'b0;
    bus.sv = sv_t'(1);
    bus.code_phase_half = '0;
    bus.dop_index = '0;
    bus.nav_bit = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_flags", {bus.busy, bus.out_valid, bus.done, bus.sample_out}, 4'b0000);
    rst = 1'b0;
    @(negedge clk);
    check("idle_flags", {bus.busy, bus.out_valid, bus.done, bus.sample_out}, 4'b0000);
    burst(1, 0, 10, 1'b0, -1, -1, -1, 100, nd);
`ifdef L1CA_SIGGEN_NOISE_EN
    check("noise_rate", int'(nd >= 2250 && nd <= 2550), 1);
`endif
    burst(5, 600, 13, 1'b0, 1000, -1, 300, 100, nd);
    burst(int'($urandom_range(1, 32)), int'($urandom_range(2046, 2047)), 25, 1'($urandom), -1, 500, -1, 100, nd);
    burst(int'($urandom_range(1, 32)), int'($urandom_range(0, 2047)), int'($urandom_range(0, 31)), 1'($urandom),
          int'($urandom_range(100, 1500)), 2500, 1200, 75, nd);
    burst(int'($urandom_range(1, 32)), int'($urandom_range(0, 2047)), int'($urandom_range(0, 20)), 1'($urandom),
          -1, 1500, -1, 60, nd);
    @(negedge clk);
    check("final_idle", {bus.busy, bus.out_valid, bus.done, bus.sample_out}, 4'b0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/l1ca_siggen.md
L1CA_SIGGEN -- requirements
Module: l1ca_siggen

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 19200, setting the samples per burst (1 ms at 19.2 Msps).
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: a one-cycle request for a burst; sampled only in IDLE.
REQ-005 SHALL have port sv, input, sv_t: PRN to transmit (1..32).
REQ-006 SHALL have port code_phase_half, input, 11 bits: code offset in half-chips (0..2045).
REQ-007 SHALL have port dop_index, input, 5 bits: Doppler bin (0..20).
REQ-008 SHALL have port nav_bit, input, 1 bit: data bit XORed onto every sample of the burst.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts sample_out.
REQ-010 SHALL have port sample_out, output, 1 bit: the generated 1-bit IF sample.
REQ-011 SHALL have port out_valid, output, 1 bit: sample_out is valid.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when the burst completes.

Function
REQ-014 SHALL use states IDLE, WIND and RUN.
- IDLE -> WIND on start.
- WIND -> RUN when code chip equals code_phase_half[10:1].
- RUN -> IDLE after N_SAMPLES handshakes.
REQ-015 SHALL latch sv, code_phase_half, dop_index and nav_bit on start, and ignore the live inputs until the next IDLE.
REQ-016 SHALL clamp a latched code_phase_half above 2045 to 2045 and a latched dop_index above 20 to 20.
REQ-017 SHALL instantiate the existing l1ca_code generator with nrst driven by ~rst; the generator is cleared in IDLE and strobed once per WIND cycle until the chip matches.
REQ-018 SHALL, on entering RUN, set the 32-bit code NCO to 32'h8000_0000 if code_phase_half[0]=1, else 0, and clear the carrier NCO.
REQ-019 SHALL assert out_valid exactly code_phase_half[10:1]+2 cycles after start is sampled, and hold it high throughout RUN.
REQ-020 SHALL compute sample_out = code ^ nav_bit ^ LO_SIN[carrier_phase[31:30]], with LO_SIN = 4'b0011.
REQ-021 SHALL, on each handshake (out_valid & out_ready), do all of the following:
- add CODE_RATE = 228841226 to the code NCO modulo 2^32, strobing l1ca_code on carry-out;
- add LO_RATE[dop_index] to the carrier NCO modulo 2^32, using the 21-entry table 898140296 ... 900377258 in steps of ~111848 (entry 10 = 899258777);
- increment a 15-bit sample counter.
REQ-022 SHALL hold sample_out and all NCO state unchanged while out_valid=1 and out_ready=0.
REQ-023 SHALL, on the handshake of sample N_SAMPLES-1, deassert out_valid on the next cycle, pulse done for one cycle, and return to IDLE.
REQ-024 SHALL ignore start while busy=1.
REQ-025 SHALL drive sample_out=0 whenever out_valid=0.

Reset
REQ-026 SHALL, while rst=1 on a clk edge, enter IDLE and clear the NCOs, the sample counter and all latched inputs.
REQ-027 SHALL have reset values out_valid=0, busy=0, done=0 and sample_out=0.
REQ-028 SHALL, if reset is applied mid-WIND or mid-RUN, abort the burst with no done pulse, and be startable the cycle after rst falls.

Configuration
REQ-029 SHALL, when macro L1CA_SIGGEN_NOISE_EN is defined, add a 16-bit Galois LFSR with polynomial x^16+x^14+x^13+x^11+1.
- The LFSR is seeded 16'hACE1 on reset and on start, and advances once per handshake.
- sample_out is inverted whenever lfsr[2:0]==3'b000 (1/8 flip rate).
REQ-030 SHALL, when L1CA_SIGGEN_NOISE_EN is undefined, contain no LFSR and produce the noise-free output of REQ-020.

Verification
REQ-031 SHALL cover reset: rst=1 for 3 cycles -> busy=0, out_valid=0, done=0, sample_out=0.
REQ-032 SHALL cover a basic burst: sv=1, code_phase_half=0, dop_index=10, nav_bit=0, out_ready=1 -> out_valid rises 2 cycles after start; first sample_out = 1^1 = 0; exactly 19200 valid cycles; done pulses once.
REQ-033 SHALL cover loopback: the output is fed to l1ca_search, with sv=5, code_phase_half=600, dop_index=13 -> search reports code_index=600, dop_index=13.
REQ-034 SHALL cover backpressure: out_ready=0 for 5 cycles at sample 1000 -> sample_out is stable across the stall; 19200 handshakes total; the output sequence is identical to the no-stall run.
REQ-035 SHALL cover control and clamping:
- start pulsed mid-RUN -> ignored;
- rst asserted at sample 500 -> IDLE next cycle, no done pulse;
- dop_index=25 -> output identical to dop_index=20.
REQ-036 SHALL cover the noise build: with L1CA_SIGGEN_NOISE_EN defined, the same inputs as REQ-032 -> sample_out differs from the noise-free run on 2400 +/- 150 of 19200 samples.
